// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU command sequencer.
// Contents:
//   OP_W, MODE_W, RES_W, TAG_W : operand, mode, result and tag widths
//   cmd_t                      : one buffered command (tag field only with ALU_SEQ_TAG_EN)
//   seq_state_t                : sequencer FSM states
// Optional feature macro: ALU_SEQ_TAG_EN
package alu_seq_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned RES_W  = 5;
  localparam int unsigned TAG_W  = 8;

  typedef struct packed {
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [MODE_W-1:0] mode;
`ifdef ALU_SEQ_TAG_EN
    logic [TAG_W-1:0]  tag;
`endif
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between a command producer / ALU / result consumer and the sequencer.
// Signals:
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_mode : command port
//   alu_a/alu_b/alu_mode/alu_y               : ALU operand drive and result return
//   res_valid/res_ready/res_y/res_mode       : result port
//   busy                                     : sequencer has work queued or in flight
//   res_tag                                  : accept-order tag (only with ALU_SEQ_TAG_EN)
// Modports: slave = sequencer side, master = environment side.
interface alu_cmd_sequencer_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_a;
  logic [OP_W-1:0]   cmd_b;
  logic [MODE_W-1:0] cmd_mode;

  logic [OP_W-1:0]   alu_a;
  logic [OP_W-1:0]   alu_b;
  logic [MODE_W-1:0] alu_mode;
  logic [RES_W-1:0]  alu_y;

  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_y;
  logic [MODE_W-1:0] res_mode;
  logic              busy;
`ifdef ALU_SEQ_TAG_EN
  logic [TAG_W-1:0]  res_tag;
`endif

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_mode, alu_y, res_ready,
`ifdef ALU_SEQ_TAG_EN
    output res_tag,
`endif
    output cmd_ready, alu_a, alu_b, alu_mode, res_valid, res_y, res_mode, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_mode, alu_y, res_ready,
`ifdef ALU_SEQ_TAG_EN
    input  res_tag,
`endif
    input  cmd_ready, alu_a, alu_b, alu_mode, res_valid, res_y, res_mode, busy
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of cmd_t, first-word-fall-through read.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_push, i_data : write request and data (ignored when full)
//   i_pop          : read request (ignored when empty); o_data is the current head
//   o_full/o_empty : status
//   o_count        : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  cmd_t            i_data,
  input  logic            i_pop,
  output cmd_t            o_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [CntW-1:0] o_count
);

  cmd_t            r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Upstream feeder for a clocked 4-bit ALU. Buffers commands in a FIFO, drives one op at a
// time into the ALU, waits out the ALU latency, captures Y and offers it on a result port.
// Parameters:
//   DEPTH   : command FIFO entries (power of two, >= 2)
//   ALU_LAT : cycles from ALU operand drive to valid Y (>= 1)
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_cmd_sequencer_if.slave (command, ALU and result signals, busy)
// Optional feature macro: ALU_SEQ_TAG_EN adds an 8-bit accept-order tag per command,
// returned on bus.res_tag alongside each result.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  alu_cmd_sequencer_if.slave bus
);

  localparam int unsigned CntW     = $clog2(ALU_LAT + 1);
  localparam int unsigned FifoCntW = $clog2(DEPTH + 1);

  seq_state_t        r_state;
  logic [CntW-1:0]   r_cnt;
  logic [OP_W-1:0]   r_alu_a;
  logic [OP_W-1:0]   r_alu_b;
  logic [MODE_W-1:0] r_alu_mode;
  logic              r_res_valid;
  logic [RES_W-1:0]  r_res_y;
  logic [MODE_W-1:0] r_res_mode;

  cmd_t                w_push_data;
  cmd_t                w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic [FifoCntW-1:0] w_count;

`ifdef ALU_SEQ_TAG_EN
  logic [TAG_W-1:0] r_acc_cnt;
  logic [TAG_W-1:0] r_alu_tag;
  logic [TAG_W-1:0] r_res_tag;

  // Accept counter wraps 255 -> 0 by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_cnt <= '0;
    end else if (bus.cmd_valid && !w_full) begin
      r_acc_cnt <= r_acc_cnt + 1'b1;
    end
  end

  assign bus.res_tag = r_res_tag;
`endif

  always_comb begin
    w_push_data      = '0;
    w_push_data.a    = bus.cmd_a;
    w_push_data.b    = bus.cmd_b;
    w_push_data.mode = bus.cmd_mode;
`ifdef ALU_SEQ_TAG_EN
    w_push_data.tag  = r_acc_cnt;
`endif
  end

  assign w_pop = (r_state == IDLE) && !w_empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.cmd_valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // The ALU registers its operands on the first edge after we drive them, so Y is only
  // safe to sample ALU_LAT edges after that: WAIT spans ALU_LAT + 1 edges in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_mode  <= '0;
      r_res_valid <= 1'b0;
      r_res_y     <= '0;
      r_res_mode  <= '0;
`ifdef ALU_SEQ_TAG_EN
      r_alu_tag   <= '0;
      r_res_tag   <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_alu_a    <= w_head.a;
            r_alu_b    <= w_head.b;
            r_alu_mode <= w_head.mode;
`ifdef ALU_SEQ_TAG_EN
            r_alu_tag  <= w_head.tag;
`endif
            r_cnt      <= CntW'(ALU_LAT);
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_res_y     <= bus.alu_y;
            r_res_mode  <= r_alu_mode;
`ifdef ALU_SEQ_TAG_EN
            r_res_tag   <= r_alu_tag;
`endif
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !w_full;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_mode  = r_alu_mode;
  assign bus.res_valid = r_res_valid;
  assign bus.res_y     = r_res_y;
  assign bus.res_mode  = r_res_mode;
  assign bus.busy      = (w_count != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer (DEPTH=4, ALU_LAT=1) with a registered adder
// standing in for the ALU. Define ALU_SEQ_TAG_EN to also exercise the tag path.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(
    .DEPTH   (4),
    .ALU_LAT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU stand-in: one registered stage, Y = A + B.
  always @(posedge clk) bus.alu_y <= {1'b0, bus.alu_a} + {1'b0, bus.alu_b};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted command must come back once, in order, as a+b.
  typedef struct {
    int y;
    int mode;
    int tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   acc_cnt   = 0;
  int   res_count = 0;

  // Inputs change 1 time unit after posedge, so negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc_cnt = 0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        res_count++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_result: got res_y=%0d, expected no result", bus.res_y);
        end else begin
          e = q.pop_front();
          check("sb_res_y", int'(bus.res_y), e.y);
          check("sb_res_mode", int'(bus.res_mode), e.mode);
`ifdef ALU_SEQ_TAG_EN
          check("sb_res_tag", int'(bus.res_tag), e.tag);
`endif
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        q.push_back('{y: int'(bus.cmd_a) + int'(bus.cmd_b), mode: int'(bus.cmd_mode),
                      tag: acc_cnt % 256});
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m,
                      output int n);
    logic rdy;
    n             = 0;
    rdy           = 1'b0;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_mode  = m;
    bus.cmd_valid = 1'b1;
    while (!rdy && n < 50) begin
      rdy = bus.cmd_ready;
      tick();
      n++;
    end
    bus.cmd_valid = 1'b0;
    check("push_accepted", int'(rdy), 1);
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.res_valid) begin
        lat = i;
        break;
      end
    end
    check("res_valid_seen", int'(bus.res_valid), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.res_ready = 1'b1;
    while ((bus.busy || bus.res_valid) && n < 400) begin
      tick();
      n++;
    end
    check("drain_idle", int'(bus.busy || bus.res_valid), 0);
    check("sb_all_returned", q.size(), 0);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_mode  = '0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] mode;
    logic [4:0] y;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   tot;
    int   lat;
    int   base;
    bit   ok;
    bit   done;
    logic [4:0] y0;
    logic [1:0] m0;

    vecs[0] = '{a: 4'hF, b: 4'h1, mode: 2'b01, y: 5'h10};
    vecs[1] = '{a: 4'h0, b: 4'h0, mode: 2'b00, y: 5'h00};
    vecs[2] = '{a: 4'hF, b: 4'hF, mode: 2'b11, y: 5'h1E};
    vecs[3] = '{a: 4'h8, b: 4'h8, mode: 2'b10, y: 5'h10};
    vecs[4] = '{a: 4'h7, b: 4'h3, mode: 2'b00, y: 5'h0A};
    vecs[5] = '{a: 4'h9, b: 4'hE, mode: 2'b01, y: 5'h17};

    // Reset state.
    do_reset();
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_res_y", int'(bus.res_y), 0);
    check("rst_res_mode", int'(bus.res_mode), 0);
    check("rst_alu_a", int'(bus.alu_a), 0);
    check("rst_alu_b", int'(bus.alu_b), 0);
    check("rst_alu_mode", int'(bus.alu_mode), 0);
`ifdef ALU_SEQ_TAG_EN
    check("rst_res_tag", int'(bus.res_tag), 0);
`endif

    // Single ops from idle: accept edge, pop on the next edge, res_valid 2 edges later.
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].mode, n);
      wait_res(lat);
      check("vec_latency", lat, 3);
      check("vec_res_y", int'(bus.res_y), int'(vecs[i].y));
      check("vec_res_mode", int'(bus.res_mode), int'(vecs[i].mode));
      tick();
      check("vec_res_consumed", int'(bus.res_valid), 0);
      check("vec_idle", int'(bus.busy), 0);
    end

    // Fill: five back-to-back with the result port stalled; one sits in the ALU path.
    bus.res_ready = 1'b0;
    base = res_count;
    tot  = 0;
    for (int i = 0; i < 5; i++) begin
      push(4'(i + 1), 4'(2 * i), 2'(i), n);
      tot += n;
    end
    check("fill_back_to_back", tot, 5);
    check("fill_cmd_ready_low", int'(bus.cmd_ready), 0);
    bus.cmd_a     = 4'h2;
    bus.cmd_b     = 4'h2;
    bus.cmd_mode  = 2'b00;
    bus.cmd_valid = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      tick();
      ok = ok && !bus.cmd_ready;
    end
    bus.cmd_valid = 1'b0;
    check("fill_stays_full", int'(ok), 1);
    drain();
    check("fill_result_count", res_count - base, 5);

    // Backpressure: result frozen in HOLD, no new op pulled into the ALU.
    bus.res_ready = 1'b0;
    push(4'h5, 4'h6, 2'b10, n);
    wait_res(lat);
    check("bp_res_y", int'(bus.res_y), 11);
    y0 = bus.res_y;
    m0 = bus.res_mode;
    push(4'h1, 4'h1, 2'b11, n);
    ok = 1'b1;
    repeat (10) begin
      tick();
      ok = ok && bus.res_valid && (bus.res_y == y0) && (bus.res_mode == m0) &&
           (bus.alu_a == 4'h5);
    end
    check("bp_stable", int'(ok), 1);
    drain();

    // Simultaneous push and pop with three queued: occupancy must stay at three.
    bus.res_ready = 1'b0;
    push(4'h3, 4'h4, 2'b01, n);
    wait_res(lat);
    push(4'hA, 4'h1, 2'b00, n);
    push(4'hB, 4'h2, 2'b01, n);
    push(4'hC, 4'h3, 2'b10, n);
    bus.res_ready = 1'b1;
    tick();
    check("pp_consumed", int'(bus.res_valid), 0);
    bus.cmd_a     = 4'hD;
    bus.cmd_b     = 4'h4;
    bus.cmd_mode  = 2'b11;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("pp_count_kept", int'(bus.cmd_ready), 1);
    push(4'hE, 4'h5, 2'b00, n);
    check("pp_then_full", int'(bus.cmd_ready), 0);
    drain();

    // Reset while the second op is in WAIT with three more queued.
    bus.res_ready = 1'b0;
    push(4'h1, 4'h2, 2'b01, n);
    wait_res(lat);
    for (int i = 0; i < 4; i++) push(4'(i + 6), 4'h1, 2'(i), n);
    bus.res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_res_valid", int'(bus.res_valid), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_cmd_ready", int'(bus.cmd_ready), 1);
    ok = 1'b1;
    repeat (12) begin
      tick();
      ok = ok && !bus.res_valid;
    end
    check("mid_rst_no_stale", int'(ok), 1);

    // Random stream with random result backpressure; covers pointer wrap many times.
    base = res_count;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)), n);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.res_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    drain();
    check("rand_result_count", res_count - base, 60);

`ifdef ALU_SEQ_TAG_EN
    // Tag wrap: 258 ops from reset give tags 0..255, 0, 1 (checked by the scoreboard).
    do_reset();
    bus.res_ready = 1'b1;
    base = res_count;
    for (int i = 0; i < 258; i++) begin
      push(4'(i), 4'(i >> 4), 2'(i), n);
    end
    drain();
    check("tag_result_count", res_count - base, 258);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
